alu_issue_stage: RTL
====================

// Module: alu_issue_stage
// PURPOSE
//   ID->EX issue stage that feeds the ALU. Accepts decoded MIPS instruction fields and register
//   operands from decode, applies write-back forwarding, and maps opcode/funct to the 3-bit
//   ALU_OP code. It selects and extends operands, then presents A, B and ALU_OP registered to the
//   ALU through a 2-entry skid buffer with valid/ready handshakes.
// PARAMETERS
//   XLEN      32  operand/result width
//   RADDR_W   5   register address width
// PORTS
//   CLK        in   1      clock; all state updates on rising edge
//   RST        in   1      synchronous, active-high reset
//   flush      in   1      drop all buffered entries (branch/exception)
//   in_valid   in   1      decode presents an instruction
//   in_ready   out  1      stage can accept (buffer not FULL)
//   opcode     in   6      instr[31:26]
//   funct      in   6      instr[5:0]
//   shamt      in   5      instr[10:6]
//   imm16      in   16     instr[15:0]
//   rs_addr    in   5      source register addresses (rs)
//   rt_addr    in   5      source register addresses (rt)
//   rd_addr    in   5      R-type destination
//   rs_data    in   XLEN   register-file read data
//   rt_data    in   XLEN   register-file read data
//   wb_we      in   1      write-back forwarding: write enable
//   wb_addr    in   5      write-back forwarding: address
//   wb_data    in   XLEN   write-back forwarding: data
//   out_valid  out  1      ALU inputs valid
//   out_ready  in   1      EX consumes current entry
//   A          out  XLEN   ALU operand A
//   B          out  XLEN   ALU operand B
//   ALU_OP     out  3      0 and,1 or,2 xor,3 nor,4 add,5 sub,6 slt,7 sll (F=B<<A)
//   dst_addr   out  5      write-back register (0 = none)
//   ovf_chk    out  1      signed-overflow trap enabled (add/sub/addi)
//   illegal    out  1      unsupported opcode/funct
// BEHAVIOUR
//   Reset: state EMPTY; out_valid=0, in_ready=1; A=B=0, ALU_OP=0, dst_addr=0, ovf_chk=0, illegal=0.
//   Accept when in_valid&in_ready; transfer out when out_valid&out_ready.
//   FSM (2 entries: head drives outputs, skid holds one extra):
//     EMPTY -acc-> ONE
//     ONE   -acc&~xfer-> FULL
//     ONE   -xfer&~acc-> EMPTY
//     ONE   -acc&xfer-> ONE (new entry to head)
//     FULL  -xfer-> ONE (skid moves to head same edge)
//   in_ready = (state!=FULL), taken from a register, with no combinational path from out_ready.
//   Latency: accepted instruction appears on A/B/ALU_OP the next cycle when the buffer was
//     EMPTY, or was ONE with a transfer in the same cycle.
//   Outputs are held stable while out_valid & ~out_ready.
//   flush: next state EMPTY; out_valid=0 next cycle. An input offered in the same cycle is dropped.
//     flush has priority over accept and transfer. RST has priority over flush.
//   Forwarding (at accept only): if wb_we & wb_addr!=0 & wb_addr==rs_addr, use wb_data for rs.
//     The same rule applies to rt. Register 0 always reads as 0.
//   Decode, opcode 0 (R-type), by funct:
//     24 and, 25 or, 26 xor, 27 nor: A=rs, B=rt
//     20/21 add, 22/23 sub, 2A slt: A=rs, B=rt; ovf_chk=1 for 20 and 22 only
//     00 sll: A=zext(shamt), B=rt
//     dst = rd_addr
//   Decode, I-type (dst=rt_addr, A=rs):
//     08/09 addi/addiu: B=sext(imm), op add; ovf_chk only for 08
//     0A slti: B=sext(imm), op slt
//     0C/0D/0E andi/ori/xori: B=zext(imm)
//     0F lui: A=16, B=zext(imm), op sll
//     23 lw, 2B sw: B=sext(imm), op add; dst=0 for sw
//     04 beq: B=rt, op sub, dst=0
//   Any other combination: illegal=1, ALU_OP=0, A=B=0, dst=0; the entry still flows through.
//   Simultaneous accept+transfer in FULL cannot occur because in_ready=0.
// STRUCTURE
//   Shared package mips_defs.vh:
//     ALU_OP localparams (ALU_AND..ALU_SLL)
//     opcode/funct localparams (OP_RTYPE, FN_ADD, ...)
//     entry width constant
//   Sub-module alu_op_decode: combinational opcode/funct -> {ALU_OP, selA, selB, ext, ovf_chk, illegal}.
//   The skid buffer and FSM stay in this module.
// TESTING
//   1. Reset: RST=1 two cycles -> out_valid=0, in_ready=1, A=B=0.
//   2. add $3,$1,$2 with rs=5, rt=7 -> next cycle A=5, B=7, ALU_OP=4, dst=3, ovf_chk=1.
//   3. Operand extension:
//      - andi imm=0xFFFF -> B=0x0000FFFF, op 0.
//      - addi imm=0xFFFF -> B=0xFFFFFFFF, op 4.
//      - lui imm=0x1234 -> A=16, B=0x1234, op 7.
//   4. Backpressure: out_ready=0, issue 3 instructions.
//      - Buffer takes 2, then in_ready=0 and head is held stable.
//      - Raise out_ready -> entries drain in order, with no loss or duplication.
//   5. Forwarding:
//      - wb_we=1, wb_addr=1, wb_data=0xDEAD, rs_addr=1 -> A=0xDEAD.
//      - Same with wb_addr=0 -> rs_data used.
//   6. Flush while FULL with in_valid=1 -> next cycle out_valid=0, in_ready=1; offered instruction dropped.

Source files
------------

// File: rtl/alu_issue_stage_pkg.sv
// Shared definitions for the ALU issue stage: ALU operation codes, MIPS opcode/funct
// values, operand-select encodings and the buffered-entry width helper.
package alu_issue_stage_pkg;

    localparam int XLEN_DEF    = 32;
    localparam int RADDR_W_DEF = 5;
    localparam int LUI_SHIFT   = 16;

    typedef enum logic [2:0] {
        ALU_AND = 3'd0,
        ALU_OR  = 3'd1,
        ALU_XOR = 3'd2,
        ALU_NOR = 3'd3,
        ALU_ADD = 3'd4,
        ALU_SUB = 3'd5,
        ALU_SLT = 3'd6,
        ALU_SLL = 3'd7
    } alu_op_e;

    typedef enum logic [1:0] {SEL_A_ZERO, SEL_A_RS, SEL_A_SHAMT, SEL_A_LUI} sel_a_e;
    typedef enum logic [1:0] {SEL_B_ZERO, SEL_B_RT, SEL_B_IMM} sel_b_e;
    typedef enum logic       {EXT_ZERO, EXT_SIGN} ext_e;
    typedef enum logic [1:0] {DST_NONE, DST_RD, DST_RT} dst_sel_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    // One buffered entry: {A, B, ALU_OP, dst_addr, ovf_chk, illegal}.
    function automatic int entry_width(input int xlen, input int raddr_w);
        return 2 * xlen + 3 + raddr_w + 2;
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational MIPS opcode/funct decode into ALU operation, operand selects,
// immediate extension, destination select, overflow-trap enable and illegal flag.
module alu_op_decode
    import alu_issue_stage_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output alu_op_e    alu_op,
    output sel_a_e     sel_a,
    output sel_b_e     sel_b,
    output ext_e       ext,
    output dst_sel_e   dst_sel,
    output logic       ovf_chk,
    output logic       illegal
);

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        alu_op  = ALU_AND;
        sel_a   = SEL_A_ZERO;
        sel_b   = SEL_B_ZERO;
        ext     = EXT_ZERO;
        dst_sel = DST_NONE;
        ovf_chk = 1'b0;
        illegal = 1'b0;

        case (opcode)
            OP_RTYPE: begin
                sel_a   = SEL_A_RS;
                sel_b   = SEL_B_RT;
                dst_sel = DST_RD;
                case (funct)
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_XOR:  alu_op = ALU_XOR;
                    FN_NOR:  alu_op = ALU_NOR;
                    FN_ADD:  begin alu_op = ALU_ADD; ovf_chk = 1'b1; end
                    FN_ADDU: alu_op = ALU_ADD;
                    FN_SUB:  begin alu_op = ALU_SUB; ovf_chk = 1'b1; end
                    FN_SUBU: alu_op = ALU_SUB;
                    FN_SLT:  alu_op = ALU_SLT;
                    FN_SLL:  begin alu_op = ALU_SLL; sel_a = SEL_A_SHAMT; end
                    default: illegal = 1'b1;
                endcase
            end
            OP_ADDI:  begin alu_op = ALU_ADD; ext = EXT_SIGN; ovf_chk = 1'b1; end
            OP_ADDIU: begin alu_op = ALU_ADD; ext = EXT_SIGN; end
            OP_SLTI:  begin alu_op = ALU_SLT; ext = EXT_SIGN; end
            OP_ANDI:  alu_op = ALU_AND;
            OP_ORI:   alu_op = ALU_OR;
            OP_XORI:  alu_op = ALU_XOR;
            OP_LUI:   alu_op = ALU_SLL;
            OP_LW:    begin alu_op = ALU_ADD; ext = EXT_SIGN; end
            OP_SW:    begin alu_op = ALU_ADD; ext = EXT_SIGN; end
            OP_BEQ:   alu_op = ALU_SUB;
            default:  illegal = 1'b1;
        endcase

        // Shared I-type operand/destination selection; lui swaps in the shift amount.
        if (opcode != OP_RTYPE && !illegal) begin
            sel_a   = (opcode == OP_LUI) ? SEL_A_LUI : SEL_A_RS;
            sel_b   = (opcode == OP_BEQ) ? SEL_B_RT  : SEL_B_IMM;
            dst_sel = (opcode == OP_SW || opcode == OP_BEQ) ? DST_NONE : DST_RT;
        end

        if (illegal) begin
            alu_op  = ALU_AND;
            sel_a   = SEL_A_ZERO;
            sel_b   = SEL_B_ZERO;
            dst_sel = DST_NONE;
            ovf_chk = 1'b0;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ID->EX issue stage: forwards write-back data, decodes and extends operands, and
// presents {A, B, ALU_OP} to the ALU through a two-entry skid buffer.
module alu_issue_stage
    import alu_issue_stage_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int RADDR_W = RADDR_W_DEF
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic [4:0]         shamt,
    input  logic [15:0]        imm16,
    input  logic [RADDR_W-1:0] rs_addr,
    input  logic [RADDR_W-1:0] rt_addr,
    input  logic [RADDR_W-1:0] rd_addr,
    input  logic [XLEN-1:0]    rs_data,
    input  logic [XLEN-1:0]    rt_data,
    input  logic               wb_we,
    input  logic [RADDR_W-1:0] wb_addr,
    input  logic [XLEN-1:0]    wb_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    A,
    output logic [XLEN-1:0]    B,
    output logic [2:0]         ALU_OP,
    output logic [RADDR_W-1:0] dst_addr,
    output logic               ovf_chk,
    output logic               illegal
);

    localparam int ENTRY_W = entry_width(XLEN, RADDR_W);

    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} state_e;

    state_e             state_q, state_d;
    logic [ENTRY_W-1:0] head_q, head_d;
    logic [ENTRY_W-1:0] skid_q, skid_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;

    alu_op_e  dec_op;
    sel_a_e   dec_sel_a;
    sel_b_e   dec_sel_b;
    ext_e     dec_ext;
    dst_sel_e dec_dst_sel;
    logic     dec_ovf_chk;
    logic     dec_illegal;

    alu_op_decode u_decode (
        .opcode  (opcode),
        .funct   (funct),
        .alu_op  (dec_op),
        .sel_a   (dec_sel_a),
        .sel_b   (dec_sel_b),
        .ext     (dec_ext),
        .dst_sel (dec_dst_sel),
        .ovf_chk (dec_ovf_chk),
        .illegal (dec_illegal)
    );

    logic [XLEN-1:0]    rs_val, rt_val, imm_ext, op_a, op_b;
    logic [RADDR_W-1:0] dst;
    logic [2:0]         op_code;
    logic [ENTRY_W-1:0] new_entry;

    always_comb begin
        rs_val = rs_data;
        rt_val = rt_data;
        if (rs_addr == '0)
            rs_val = '0;
        else if (wb_we && wb_addr == rs_addr)
            rs_val = wb_data;
        if (rt_addr == '0)
            rt_val = '0;
        else if (wb_we && wb_addr == rt_addr)
            rt_val = wb_data;

        imm_ext = (dec_ext == EXT_SIGN) ? {{(XLEN-16){imm16[15]}}, imm16}
                                        : {{(XLEN-16){1'b0}}, imm16};

        case (dec_sel_a)
            SEL_A_RS:    op_a = rs_val;
            SEL_A_SHAMT: op_a = XLEN'(shamt);
            SEL_A_LUI:   op_a = XLEN'(LUI_SHIFT);
            default:     op_a = '0;
        endcase

        case (dec_sel_b)
            SEL_B_RT:  op_b = rt_val;
            SEL_B_IMM: op_b = imm_ext;
            default:   op_b = '0;
        endcase

        case (dec_dst_sel)
            DST_RD:  dst = rd_addr;
            DST_RT:  dst = rt_addr;
            default: dst = '0;
        endcase

        op_code   = dec_op;
        new_entry = {op_a, op_b, op_code, dst, dec_ovf_chk, dec_illegal};
    end

    logic acc, xfer;
    assign acc  = in_valid && in_ready_q;
    assign xfer = out_valid_q && out_ready;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;

        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: if (acc) begin
                    head_d  = new_entry;
                    state_d = ST_ONE;
                end
                ST_ONE: begin
                    if (acc && xfer) begin
                        head_d = new_entry;
                    end else if (acc) begin
                        skid_d  = new_entry;
                        state_d = ST_FULL;
                    end else if (xfer) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: if (xfer) begin
                    head_d  = skid_q;
                    state_d = ST_ONE;
                end
                default: state_d = ST_EMPTY;
            endcase
        end

        // Handshake flags are registered copies of the next state, keeping out_ready off in_ready.
        in_ready_d  = (state_d != ST_FULL);
        out_valid_d = (state_d != ST_EMPTY);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            // NOTE: the entries are reset too, since A/B/ALU_OP must read zero out of reset.
            state_q     <= ST_EMPTY;
            head_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign {A, B, ALU_OP, dst_addr, ovf_chk, illegal} = head_q;

endmodule
